// File: rtl/rot_sw_pkg.sv
// rot_sw_pkg: shared types and constants for the rotary switch debouncer.
// State encoding, default timing parameters and direction helper.
package rot_sw_pkg;

  localparam int CODE_W         = 4;
  localparam int DEF_TICK_DIV   = 50000;
  localparam int DEF_STABLE_CNT = 4;

  typedef enum logic [1:0] {
    ST_ACQ,
    ST_IDLE,
    ST_CHECK
  } state_e;

  // Clockwise when the forward distance new-old (mod 16) is 1..7.
  function automatic logic cw_step(
    input logic [CODE_W-1:0] nw,
    input logic [CODE_W-1:0] old
  );
    logic [CODE_W-1:0] d;
    d = nw - old;
    return (d != '0) && !d[CODE_W-1];
  endfunction

endpackage

// File: rtl/rot_sw_tick.sv
// rot_sw_tick: sample-tick prescaler for the rotary switch debouncer.
// Counts 0..TICK_DIV-1 and flags the last count as TICK.
module rot_sw_tick
  import rot_sw_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_w;

  // Wrap on the last count, otherwise advance.
  always_comb begin
    tick_w = (cnt_q == LAST);
    cnt_d  = tick_w ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign TICK = tick_w;

endmodule

// File: rtl/rot_sw_debounce.sv
// rot_sw_debounce: synchronise and debounce a 4-bit rotary switch code.
// Define ROT_SW_DIR_EN to add the R_DIR rotation-direction output.
module rot_sw_debounce
  import rot_sw_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT,
  parameter int INV_IN     = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [CODE_W-1:0] R_IN,
  output logic [CODE_W-1:0] R_OUT,
  output logic              R_CHG,
`ifdef ROT_SW_DIR_EN
  output logic              R_DIR,
`endif
  output logic              R_VALID
);

  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [CODE_W-1:0] in_w;
  logic [CODE_W-1:0] sync1_q, sync1_d;
  logic [CODE_W-1:0] sync2_q, sync2_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tick;
  logic              same;
  logic              accept;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] out_q, out_d;
  logic              chg_q, chg_d;
  logic              valid_q, valid_d;
  logic              differs;
`ifdef ROT_SW_DIR_EN
  logic              dir_q, dir_d;
`endif

  rot_sw_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .TICK  (tick)
  );

  assign in_w = (INV_IN != 0) ? ~R_IN : R_IN;

  // Two-flop synchroniser; second stage is the sample value.
  always_comb begin
    sync1_d = in_w;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Candidate tracking: restart on a new code, count equal ticks.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    same   = (sync2_q == cand_q);
    accept = tick && same && (cnt_q == CMAX);
    if (tick) begin
      if (!same) begin
        cand_d = sync2_q;
        cnt_d  = '0;
      end else if (cnt_q != CMAX) begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output FSM: first acquisition, then change detection.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    chg_d   = 1'b0;
    valid_d = valid_q;
`ifdef ROT_SW_DIR_EN
    dir_d   = dir_q;
`endif
    differs = (cand_q != out_q);
    unique case (state_q)
      ST_ACQ: begin
        if (accept) begin
          out_d   = cand_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (differs) begin
          if (accept) begin
            out_d = cand_q;
            chg_d = 1'b1;
`ifdef ROT_SW_DIR_EN
            dir_d = cw_step(cand_q, out_q);
`endif
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (!differs) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          out_d   = cand_q;
          chg_d   = 1'b1;
`ifdef ROT_SW_DIR_EN
          dir_d   = cw_step(cand_q, out_q);
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_ACQ;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_ACQ;
      out_q   <= '0;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef ROT_SW_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
`ifdef ROT_SW_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign R_OUT   = out_q;
  assign R_CHG   = chg_q;
  assign R_VALID = valid_q;
`ifdef ROT_SW_DIR_EN
  assign R_DIR   = dir_q;
`endif

endmodule

// File: tb/tb_rot_sw_debounce.sv
// tb_rot_sw_debounce: directed bench with a sample-window reference model.
// Optional ROT_SW_DIR_EN checks the direction output too.
module tb_rot_sw_debounce;

  localparam int TD = 4;
  localparam int SC = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] R_IN = 4'h0;
  logic [3:0] R_IN2 = 4'b1110;
  logic [3:0] r_out, r_out2;
  logic       r_chg, r_chg2;
  logic       r_valid, r_valid2;
`ifdef ROT_SW_DIR_EN
  logic       r_dir, r_dir2;
`endif

  always #5 CLK = ~CLK;

  rot_sw_debounce #(
    .TICK_DIV   (TD),
    .STABLE_CNT (SC),
    .INV_IN     (0)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .R_IN    (R_IN),
    .R_OUT   (r_out),
    .R_CHG   (r_chg),
`ifdef ROT_SW_DIR_EN
    .R_DIR   (r_dir),
`endif
    .R_VALID (r_valid)
  );

  rot_sw_debounce #(
    .TICK_DIV   (TD),
    .STABLE_CNT (SC),
    .INV_IN     (1)
  ) dut_inv (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .R_IN    (R_IN2),
    .R_OUT   (r_out2),
    .R_CHG   (r_chg2),
`ifdef ROT_SW_DIR_EN
    .R_DIR   (r_dir2),
`endif
    .R_VALID (r_valid2)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a code is taken once the last SC+1 tick
  // samples agree; the reset candidate counts as one sample of 0.
  int         n;
  int         nsamp;
  logic [3:0] win [SC];
  logic [3:0] h1, h2;
  logic [3:0] m_out;
  logic       m_valid, m_chg, m_dir;
  logic       m_tick, m_acc;
  logic [3:0] m_diff;

  always_comb begin
    m_tick = ((n % TD) == TD - 1);
    m_acc  = m_tick && (nsamp == SC);
    for (int i = 0; i < SC; i++)
      if (win[i] != h2) m_acc = 1'b0;
    m_diff = h2 - m_out;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n       <= 0;
      nsamp   <= 1;
      h1      <= 4'h0;
      h2      <= 4'h0;
      m_out   <= 4'h0;
      m_valid <= 1'b0;
      m_chg   <= 1'b0;
      m_dir   <= 1'b0;
      for (int i = 0; i < SC; i++) win[i] <= 4'h0;
    end else begin
      n     <= n + 1;
      h1    <= R_IN;
      h2    <= h1;
      m_chg <= 1'b0;
      if (m_tick) begin
        win[0] <= h2;
        for (int i = 1; i < SC; i++) win[i] <= win[i-1];
        if (nsamp < SC) nsamp <= nsamp + 1;
        if (m_acc && (!m_valid || h2 != m_out)) begin
          m_out   <= h2;
          m_valid <= 1'b1;
          if (m_valid) begin
            m_chg <= 1'b1;
            m_dir <= (m_diff inside {[4'd1:4'd7]});
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse counting.
  int   pulses = 0;
  logic prev_chg = 1'b0;

  always @(negedge CLK) begin
    if (RST_N) begin
      check("r_out", {28'b0, r_out}, {28'b0, m_out});
      check("r_valid", {31'b0, r_valid}, {31'b0, m_valid});
      check("r_chg", {31'b0, r_chg}, {31'b0, m_chg});
      check("chg_gap", {31'b0, r_chg & prev_chg}, 32'd0);
`ifdef ROT_SW_DIR_EN
      check("r_dir", {31'b0, r_dir}, {31'b0, m_dir});
`endif
      if (r_chg) pulses <= pulses + 1;
      prev_chg <= r_chg;
    end else begin
      prev_chg <= 1'b0;
    end
  end

  int base;

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!r_valid && k < 2 + TD * (SC + 1) + 1) begin
      @(negedge CLK);
      k++;
    end
    check(name, {31'b0, r_valid}, 32'd1);
  endtask

  task automatic settle(input int cyc);
    repeat (cyc) @(negedge CLK);
    #1;
  endtask

  initial begin
    // 1: reset state, first acquisition of 4'hA
    R_IN = 4'hA;
    repeat (3) @(negedge CLK);
    check("rst_out", {28'b0, r_out}, 32'h0);
    check("rst_valid", {31'b0, r_valid}, 32'd0);
    check("rst_chg", {31'b0, r_chg}, 32'd0);
    RST_N = 1'b1;
    base = pulses;
    wait_valid("acq_latency");
    check("acq_out", {28'b0, r_out}, 32'hA);
    settle(10);
    check("acq_no_chg", pulses - base, 32'd0);

    // 2: A -> 3, one pulse, counter-clockwise
    base = pulses;
    R_IN = 4'h3;
    settle(40);
    check("chg_a3_pulses", pulses - base, 32'd1);
    check("chg_a3_out", {28'b0, r_out}, 32'h3);
`ifdef ROT_SW_DIR_EN
    check("chg_a3_dir", {31'b0, r_dir}, 32'd0);
`endif

    // 3: short glitch to 5 is rejected
    @(negedge CLK);
    base = pulses;
    R_IN = 4'h5;
    repeat (5) @(negedge CLK);
    R_IN = 4'h3;
    settle(40);
    check("glitch_out", {28'b0, r_out}, 32'h3);
    check("glitch_pulses", pulses - base, 32'd0);

    // 4: walk E -> F -> 0 across the wrap
    @(negedge CLK);
    R_IN = 4'hE;
    settle(40);
    check("walk_e_out", {28'b0, r_out}, 32'hE);
    @(negedge CLK);
    base = pulses;
    R_IN = 4'hF;
    repeat (20) @(negedge CLK);
`ifdef ROT_SW_DIR_EN
    check("walk_f_dir", {31'b0, r_dir}, 32'd1);
`endif
    R_IN = 4'h0;
    settle(40);
    check("walk_pulses", pulses - base, 32'd2);
    check("walk_out", {28'b0, r_out}, 32'h0);
`ifdef ROT_SW_DIR_EN
    check("walk_0_dir", {31'b0, r_dir}, 32'd1);
`endif

    // 5: async reset while a new code is pending
    @(negedge CLK);
    R_IN = 4'h7;
    repeat (8) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_out", {28'b0, r_out}, 32'h0);
    check("arst_valid", {31'b0, r_valid}, 32'd0);
    check("arst_chg", {31'b0, r_chg}, 32'd0);
    check("arst_valid2", {31'b0, r_valid2}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    base = pulses;
    wait_valid("reacq_latency");
    check("reacq_out", {28'b0, r_out}, 32'h7);
    settle(20);
    check("reacq_no_chg", pulses - base, 32'd0);

    // 6: inverted-input instance sees ~4'b1110
    check("inv_out", {28'b0, r_out2}, 32'h1);
    check("inv_valid", {31'b0, r_valid2}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
